// File: rtl/ebi_master.sv
// ebi_master -- initiator end of the Mecobo external bus interface (EBI).
//
// Turns single-word read/write requests into timed EBI bus cycles with
// programmable setup/strobe/hold phases, returns read data and write
// acknowledges, and synchronises the remote fpga_ready interrupt line.
//
// Ports:
//   clk, rst                 system clock (sys_clk domain), async active-high reset
//   req_valid/req_ready      request handshake; req_wr, req_addr, req_wdata payload
//   rsp_valid                one-cycle completion pulse with rsp_rdata / rsp_err
//   ebi_addr, ebi_data_o     bus address and write data (held while idle)
//   ebi_data_oe              data tristate enable for the toplevel pad mux
//   ebi_data_i               bus read data
//   ebi_cs, ebi_wr, ebi_rd   active-low chip select and strobes
//   ebi_ardy                 target ready (used only with EBI_ARDY_EN)
//   ebi_irq                  asynchronous interrupt from the target
//   irq_level, irq_rise      synchronised irq and its rising-edge pulse
//
// Build option: define EBI_ARDY_EN to let the target stretch the strobe via
// ebi_ardy, with an ARDY_TIMEOUT-cycle limit that reports rsp_err.
module ebi_master #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned TURN_CYC     = 1,
    parameter int unsigned ARDY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [18:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [18:0] ebi_addr,
    output logic [15:0] ebi_data_o,
    output logic        ebi_data_oe,
    input  logic [15:0] ebi_data_i,
    output logic        ebi_cs,
    output logic        ebi_wr,
    output logic        ebi_rd,
    input  logic        ebi_ardy,
    input  logic        ebi_irq,
    output logic        irq_level,
    output logic        irq_rise
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    // Counter load values are "cycles - 1"; the phase ends when the counter is 0.
    localparam logic [15:0] SETUP_LD  = (SETUP_CYC  > 0) ? 16'(SETUP_CYC  - 1) : '0;
    localparam logic [15:0] STROBE_LD = (STROBE_CYC > 1) ? 16'(STROBE_CYC - 1) : '0;
    localparam logic [15:0] HOLD_LD   = (HOLD_CYC   > 0) ? 16'(HOLD_CYC   - 1) : '0;
    localparam logic [15:0] TURN_LD   = (TURN_CYC   > 0) ? 16'(TURN_CYC   - 1) : '0;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        txn_wr;
    logic [15:0] rdata_q;
    logic        accept, capture, done, end_strobe, timeout;
    logic        wr_sel, busy_nx;
    logic [15:0] rdata_nx;
    logic        err_nx;
    logic        cs_nx, wr_nx, rd_nx, oe_nx, ready_nx;
    logic [15:0] rsp_rdata_nx;
    logic        irq_s1;

`ifdef EBI_ARDY_EN
    logic        ardy_s1, ardy_s;
    logic [15:0] ext, ext_nx;
    logic        err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ardy_s1 <= 1'b0;
            ardy_s  <= 1'b0;
        end else begin
            ardy_s1 <= ebi_ardy;
            ardy_s  <= ardy_s1;
        end
    end
`else
    logic unused_ardy;
    assign unused_ardy = ebi_ardy ^ (ARDY_TIMEOUT == 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef EBI_ARDY_EN
            ext   <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
`ifdef EBI_ARDY_EN
            ext   <= ext_nx;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        end_strobe = 1'b0;
        timeout    = 1'b0;
`ifdef EBI_ARDY_EN
        ext_nx     = ext;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
`ifdef EBI_ARDY_EN
                    ext_nx = '0;
`endif
                    if (SETUP_CYC > 0) begin
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                    end else begin
                        state_nx = STROBE;
                        cnt_nx   = STROBE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = STROBE;
                    cnt_nx   = STROBE_LD;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            STROBE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 16'd1;
                end else begin
`ifdef EBI_ARDY_EN
                    // Minimum strobe done: stretch while the target holds ardy low.
                    if (ardy_s) begin
                        end_strobe = 1'b1;
                        capture    = ~txn_wr;
                    end else if (ext == 16'(ARDY_TIMEOUT)) begin
                        end_strobe = 1'b1;
                        timeout    = 1'b1;
                    end else begin
                        ext_nx = ext + 16'd1;
                    end
`else
                    end_strobe = 1'b1;
                    capture    = ~txn_wr;
`endif
                end
                if (end_strobe) begin
                    if (HOLD_CYC > 0) begin
                        state_nx = HOLD;
                        cnt_nx   = HOLD_LD;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    done = 1'b1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (done) begin
            if (!txn_wr && (TURN_CYC > 0)) begin
                state_nx = TURN;
                cnt_nx   = TURN_LD;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    // Output logic: computes next output values from the next state so that
    // every bus/response output comes straight from a flop.
    always_comb begin
        wr_sel       = accept ? req_wr : txn_wr;
        busy_nx      = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        cs_nx        = ~busy_nx;
        wr_nx        = ~((state_nx == STROBE) && wr_sel);
        rd_nx        = ~((state_nx == STROBE) && !wr_sel);
        oe_nx        = busy_nx && wr_sel;
        ready_nx     = (state_nx == IDLE);
        rdata_nx     = capture ? ebi_data_i : rdata_q;
`ifdef EBI_ARDY_EN
        err_nx       = timeout | err_q;
`else
        err_nx       = timeout;
`endif
        rsp_rdata_nx = rsp_rdata;
        if (done) begin
            if (txn_wr) rsp_rdata_nx = '0;
            else if (err_nx) rsp_rdata_nx = 16'hDEAD;
            else rsp_rdata_nx = rdata_nx;
        end
    end

    // Output and transaction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ebi_cs      <= 1'b1;
            ebi_wr      <= 1'b1;
            ebi_rd      <= 1'b1;
            ebi_data_oe <= 1'b0;
            ebi_addr    <= '0;
            ebi_data_o  <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            txn_wr      <= 1'b0;
            rdata_q     <= '0;
`ifdef EBI_ARDY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            ebi_cs      <= cs_nx;
            ebi_wr      <= wr_nx;
            ebi_rd      <= rd_nx;
            ebi_data_oe <= oe_nx;
            req_ready   <= ready_nx;
            rsp_valid   <= done;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_err     <= done & err_nx;
            rdata_q     <= rdata_nx;
            if (accept) begin
                txn_wr   <= req_wr;
                ebi_addr <= req_addr;
                if (req_wr) ebi_data_o <= req_wdata;
            end
`ifdef EBI_ARDY_EN
            if (accept) err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
`endif
        end
    end

    // Interrupt synchroniser, independent of the bus FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1    <= 1'b0;
            irq_level <= 1'b0;
            irq_rise  <= 1'b0;
        end else begin
            irq_s1    <= ebi_irq;
            irq_level <= irq_s1;
            irq_rise  <= irq_s1 & ~irq_level;
        end
    end

endmodule

// File: tb/tb_ebi_master.sv
module tb_ebi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        ebi_irq;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic        req_valid, req_ready, req_wr;
    logic [18:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [18:0] ebi_addr;
    logic [15:0] ebi_data_o, ebi_data_i;
    logic        ebi_data_oe, ebi_cs, ebi_wr, ebi_rd;
    logic        irq_level, irq_rise;

    ebi_master u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ebi_addr(ebi_addr), .ebi_data_o(ebi_data_o), .ebi_data_oe(ebi_data_oe),
        .ebi_data_i(ebi_data_i), .ebi_cs(ebi_cs), .ebi_wr(ebi_wr), .ebi_rd(ebi_rd),
        .ebi_ardy(1'b1), .ebi_irq(ebi_irq),
        .irq_level(irq_level), .irq_rise(irq_rise)
    );

    // Minimal-timing instance: no setup/hold, single-cycle strobe, no turnaround
    logic        f_req_valid, f_req_ready, f_req_wr;
    logic [18:0] f_req_addr;
    logic [15:0] f_req_wdata;
    logic        f_rsp_valid, f_rsp_err;
    logic [15:0] f_rsp_rdata;
    logic [18:0] f_ebi_addr;
    logic [15:0] f_ebi_data_o, f_ebi_data_i;
    logic        f_ebi_data_oe, f_ebi_cs, f_ebi_wr, f_ebi_rd;
    logic        f_irq_level, f_irq_rise;

    ebi_master #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .TURN_CYC(0)) u_fast (
        .clk(clk), .rst(rst),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wr(f_req_wr),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err),
        .ebi_addr(f_ebi_addr), .ebi_data_o(f_ebi_data_o), .ebi_data_oe(f_ebi_data_oe),
        .ebi_data_i(f_ebi_data_i), .ebi_cs(f_ebi_cs), .ebi_wr(f_ebi_wr), .ebi_rd(f_ebi_rd),
        .ebi_ardy(1'b1), .ebi_irq(1'b0),
        .irq_level(f_irq_level), .irq_rise(f_irq_rise)
    );

`ifdef EBI_ARDY_EN
    logic        a_req_valid, a_req_ready;
    logic [18:0] a_req_addr;
    logic        a_rsp_valid, a_rsp_err;
    logic [15:0] a_rsp_rdata;
    logic [18:0] a_ebi_addr;
    logic [15:0] a_ebi_data_o, a_ebi_data_i;
    logic        a_ebi_data_oe, a_ebi_cs, a_ebi_wr, a_ebi_rd, a_ardy;
    logic        a_irq_level, a_irq_rise;
    int          a_found, a_rsp_cyc, a_last_rd;
    logic [15:0] a_got_rdata;
    logic        a_got_err;

    ebi_master #(.ARDY_TIMEOUT(8)) u_ardy (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(1'b0),
        .req_addr(a_req_addr), .req_wdata(16'h0000),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .ebi_addr(a_ebi_addr), .ebi_data_o(a_ebi_data_o), .ebi_data_oe(a_ebi_data_oe),
        .ebi_data_i(a_ebi_data_i), .ebi_cs(a_ebi_cs), .ebi_wr(a_ebi_wr), .ebi_rd(a_ebi_rd),
        .ebi_ardy(a_ardy), .ebi_irq(1'b0),
        .irq_level(a_irq_level), .irq_rise(a_irq_rise)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one accepting edge; returns in cycle 1 of the transaction.
    task automatic issue(input logic wr, input logic [18:0] addr, input logic [15:0] wd, input logic keep);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        step();
        if (!keep) req_valid = 1'b0;
    endtask

    // Checks one default-timing transaction, starting in cycle 1: cs low 1..8,
    // strobe low 3..6, rsp_valid in 9, req_ready back in 9 (write) / 10 (read).
    task automatic chk_txn(input logic wr, input logic [18:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd_val);
        int last;
        logic strb;
        last = wr ? 9 : 10;
        for (int c = 1; c <= last; c++) begin
            ebi_data_i = (c >= 3 && c <= 6) ? rd_val : 16'hFFFF;
            strb = (c >= 3 && c <= 6);
            check($sformatf("cs c%0d", c), ebi_cs, (c <= 8) ? 0 : 1);
            check($sformatf("wr c%0d", c), ebi_wr, (wr && strb) ? 0 : 1);
            check($sformatf("rd c%0d", c), ebi_rd, (!wr && strb) ? 0 : 1);
            check($sformatf("oe c%0d", c), ebi_data_oe, (wr && c <= 8) ? 1 : 0);
            check($sformatf("rsp_valid c%0d", c), rsp_valid, (c == 9) ? 1 : 0);
            check($sformatf("req_ready c%0d", c), req_ready, (wr ? (c >= 9) : (c >= 10)) ? 1 : 0);
            if (c <= 8) begin
                check($sformatf("addr c%0d", c), ebi_addr, addr);
                if (wr) check($sformatf("data_o c%0d", c), ebi_data_o, wd);
            end
            if (c == 9) begin
                check("rsp_rdata", rsp_rdata, wr ? 16'h0000 : rd_val);
                check("rsp_err", rsp_err, 0);
            end
            if (c < last) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ebi_irq = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; ebi_data_i = '0;
        f_req_valid = 1'b0; f_req_wr = 1'b0; f_req_addr = '0; f_req_wdata = '0; f_ebi_data_i = '0;
`ifdef EBI_ARDY_EN
        a_req_valid = 1'b0; a_req_addr = '0; a_ebi_data_i = 16'hFFFF; a_ardy = 1'b1;
`endif
        step(); step();

        // Reset state
        check("rst cs", ebi_cs, 1);
        check("rst wr", ebi_wr, 1);
        check("rst rd", ebi_rd, 1);
        check("rst oe", ebi_data_oe, 0);
        check("rst addr", ebi_addr, 0);
        check("rst data_o", ebi_data_o, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        check("rst rsp_err", rsp_err, 0);
        check("rst irq_level", irq_level, 0);
        check("rst irq_rise", irq_rise, 0);
        check("rst req_ready", req_ready, 1);
        rst = 1'b0;
        step();

        // Single write, then idle holds address/data but releases cs/oe
        issue(1'b1, 19'h00032, 16'hA5C3, 1'b0);
        chk_txn(1'b1, 19'h00032, 16'hA5C3, 16'h0000);
        step();
        check("idle cs", ebi_cs, 1);
        check("idle oe", ebi_data_oe, 0);
        check("idle addr hold", ebi_addr, 19'h00032);
        check("idle data hold", ebi_data_o, 16'hA5C3);
        check("idle rsp_valid", rsp_valid, 0);

        // Single read
        issue(1'b0, 19'h00010, 16'h0000, 1'b0);
        chk_txn(1'b0, 19'h00010, 16'h0000, 16'h1234);
        step();

        // Back-to-back writes with req_valid held
        issue(1'b1, 19'h00100, 16'h1111, 1'b1);
        req_addr = 19'h00101; req_wdata = 16'h2222;
        chk_txn(1'b1, 19'h00100, 16'h1111, 16'h0000);
        step();
        req_valid = 1'b0;
        chk_txn(1'b1, 19'h00101, 16'h2222, 16'h0000);
        step();

        // Reset in cycle 4 of a write
        issue(1'b1, 19'h00055, 16'h0F0F, 1'b0);
        step(); step(); step();
        check("pre-rst wr low", ebi_wr, 0);
        rst = 1'b1;
        #1;
        check("async rst cs", ebi_cs, 1);
        check("async rst wr", ebi_wr, 1);
        check("async rst oe", ebi_data_oe, 0);
        check("async rst rsp_valid", rsp_valid, 0);
        step();
        rst = 1'b0;
        step();
        check("post-rst req_ready", req_ready, 1);
        check("post-rst rsp_valid", rsp_valid, 0);
        check("post-rst cs", ebi_cs, 1);
        issue(1'b0, 19'h7FFFF, 16'h0000, 1'b0);
        chk_txn(1'b0, 19'h7FFFF, 16'h0000, 16'hBEEF);
        step();

        // Minimal timing: write
        f_req_valid = 1'b1; f_req_wr = 1'b1; f_req_addr = 19'h00007; f_req_wdata = 16'h00FF;
        step();
        f_req_valid = 1'b0;
        check("fast w c1 cs", f_ebi_cs, 0);
        check("fast w c1 wr", f_ebi_wr, 0);
        check("fast w c1 rd", f_ebi_rd, 1);
        check("fast w c1 oe", f_ebi_data_oe, 1);
        check("fast w c1 data_o", f_ebi_data_o, 16'h00FF);
        check("fast w c1 addr", f_ebi_addr, 19'h00007);
        check("fast w c1 ready", f_req_ready, 0);
        check("fast w c1 rsp_valid", f_rsp_valid, 0);
        step();
        check("fast w c2 cs", f_ebi_cs, 1);
        check("fast w c2 wr", f_ebi_wr, 1);
        check("fast w c2 oe", f_ebi_data_oe, 0);
        check("fast w c2 rsp_valid", f_rsp_valid, 1);
        check("fast w c2 rdata", f_rsp_rdata, 0);
        check("fast w c2 ready", f_req_ready, 1);
        step();
        check("fast w c3 rsp_valid", f_rsp_valid, 0);

        // Minimal timing: read, TURN_CYC=0 so ready returns with the response
        f_req_valid = 1'b1; f_req_wr = 1'b0; f_req_addr = 19'h00009; f_ebi_data_i = 16'hC0DE;
        step();
        f_req_valid = 1'b0;
        check("fast r c1 cs", f_ebi_cs, 0);
        check("fast r c1 rd", f_ebi_rd, 0);
        check("fast r c1 wr", f_ebi_wr, 1);
        check("fast r c1 oe", f_ebi_data_oe, 0);
        step();
        f_ebi_data_i = 16'hFFFF;
        check("fast r c2 rd", f_ebi_rd, 1);
        check("fast r c2 rsp_valid", f_rsp_valid, 1);
        check("fast r c2 rdata", f_rsp_rdata, 16'hC0DE);
        check("fast r c2 ready", f_req_ready, 1);
        step();

        // Interrupt: 3-cycle pulse gives one irq_rise two edges later
        ebi_irq = 1'b1;
        step();
        check("irq e1 level", irq_level, 0);
        check("irq e1 rise", irq_rise, 0);
        step();
        check("irq e2 level", irq_level, 1);
        check("irq e2 rise", irq_rise, 1);
        step();
        ebi_irq = 1'b0;
        check("irq e3 level", irq_level, 1);
        check("irq e3 rise", irq_rise, 0);
        step();
        check("irq e4 rise", irq_rise, 0);
        step();
        check("irq e5 level", irq_level, 0);
        check("irq e5 rise", irq_rise, 0);

`ifdef EBI_ARDY_EN
        // ardy held low: 4 + 8 strobe cycles, then hold, then error response
        a_ardy = 1'b0; a_req_valid = 1'b1; a_req_addr = 19'h00020;
        step();
        a_req_valid = 1'b0;
        a_found = 0; a_rsp_cyc = 0; a_last_rd = 0; a_got_rdata = '0; a_got_err = 1'b0;
        for (int c = 1; c <= 40 && a_found == 0; c++) begin
            if (a_ebi_rd === 1'b0) a_last_rd = c;
            if (a_rsp_valid === 1'b1) begin
                a_found = 1; a_rsp_cyc = c; a_got_rdata = a_rsp_rdata; a_got_err = a_rsp_err;
            end
            if (a_found == 0) step();
        end
        check("ardy_to rsp seen", a_found, 1);
        check("ardy_to rsp cycle", a_rsp_cyc, 17);
        check("ardy_to last rd cycle", a_last_rd, 14);
        check("ardy_to rdata", a_got_rdata, 16'hDEAD);
        check("ardy_to err", a_got_err, 1);
        step();

        // ardy rises in cycle 9: seen after the synchroniser, strobe ends at edge 11
        a_req_valid = 1'b1; a_req_addr = 19'h00021; a_ebi_data_i = 16'hFFFF;
        step();
        a_req_valid = 1'b0;
        a_found = 0; a_rsp_cyc = 0; a_last_rd = 0; a_got_rdata = '0; a_got_err = 1'b1;
        for (int c = 1; c <= 40 && a_found == 0; c++) begin
            if (c >= 9) begin
                a_ardy = 1'b1; a_ebi_data_i = 16'h5A5A;
            end
            if (a_ebi_rd === 1'b0) a_last_rd = c;
            if (a_rsp_valid === 1'b1) begin
                a_found = 1; a_rsp_cyc = c; a_got_rdata = a_rsp_rdata; a_got_err = a_rsp_err;
            end
            if (a_found == 0) step();
        end
        check("ardy_late rsp seen", a_found, 1);
        check("ardy_late rsp cycle", a_rsp_cyc, 14);
        check("ardy_late last rd cycle", a_last_rd, 11);
        check("ardy_late rdata", a_got_rdata, 16'h5A5A);
        check("ardy_late err", a_got_err, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ebi_master.md
Name: ebi_master

Overview:
- Initiator end of the Mecobo external bus interface (EBI): 19-bit address, 16-bit data, active-low cs/wr/rd strobes, plus the fpga_ready interrupt line.
- Turns single-word read/write requests into timed EBI bus cycles with programmable setup/strobe/hold phases.
- Returns read data and write acknowledges, and synchronises the remote irq line.
- Used by bridge logic and loopback rigs that drive a Mecobo board's EBI target from RTL instead of the MCU.

Parameters:
SETUP_CYC, 2, cycles cs and address are asserted before the strobe; 0 skips the phase
STROBE_CYC, 4, cycles wr or rd is held low; minimum 1
HOLD_CYC, 2, cycles cs, address and data are held after the strobe deasserts; 0 skips the phase
TURN_CYC, 1, idle cycles after a read before req_ready rises; 0 skips the phase
ARDY_TIMEOUT, 255, maximum strobe-extension cycles (EBI_ARDY_EN only)

Ports:
clk  in  1  system clock (sys_clk domain)
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_wr  in  1  1 = write, 0 = read
req_addr  in  19  word address
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read data; 0 after a write
rsp_err  out  1  timeout flag, valid with rsp_valid
ebi_addr  out  19  bus address
ebi_data_o  out  16  bus write data
ebi_data_oe  out  1  data tristate enable (toplevel builds the pad mux)
ebi_data_i  in  16  bus read data
ebi_cs  out  1  active-low chip select
ebi_wr  out  1  active-low write strobe
ebi_rd  out  1  active-low read strobe
ebi_ardy  in  1  target ready; tie 1 when EBI_ARDY_EN is not defined
ebi_irq  in  1  asynchronous interrupt (fpga_ready) from the target
irq_level  out  1  synchronised ebi_irq
irq_rise  out  1  one-cycle pulse on a 0->1 edge of irq_level

Behaviour:
- All outputs are registered.
- Reset values:
  - ebi_cs=1, ebi_wr=1, ebi_rd=1
  - ebi_data_oe=0, ebi_addr=0, ebi_data_o=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - irq_level=0, irq_rise=0
  - req_ready=1 (IDLE)
- States: IDLE, SETUP, STROBE, HOLD, TURN.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch wr/addr/wdata and go to SETUP (or STROBE if SETUP_CYC=0).
  - req_ready drops in the next cycle.
  - Requests are never dropped; req_valid with req_ready=0 waits.
- SETUP:
  - ebi_cs=0, ebi_addr driven.
  - Writes: ebi_data_oe=1 and ebi_data_o=wdata.
  - Reads: ebi_data_oe=0.
  - Lasts SETUP_CYC cycles.
- STROBE:
  - ebi_wr=0 (write) or ebi_rd=0 (read) for STROBE_CYC cycles.
  - Reads: ebi_data_i is captured on the clock edge that ends the last strobe cycle.
- HOLD:
  - Strobes high; cs, address and write data unchanged.
  - Lasts HOLD_CYC cycles.
- Completion:
  - In the first cycle after the last HOLD cycle: ebi_cs=1, ebi_data_oe=0, rsp_valid=1 for exactly one cycle.
  - rsp_rdata = captured data for a read, 0 for a write.
  - Writes return to IDLE with req_ready=1 in that same cycle.
  - Reads go through TURN for TURN_CYC cycles with req_ready=0, then IDLE.
- Latency with defaults: request accepted at edge 0 -> cs low in cycles 1..8, strobe low in cycles 3..6, rsp_valid in cycle 9.
- Back-to-back writes leave exactly one cs-high cycle between transactions.
- Counters: one down-counter, 16 bits, loaded at each phase entry. STROBE_CYC=0 is treated as 1.
- ebi_addr and ebi_data_o hold their last values while idle; only the strobes and oe return to the inactive level.
- Interrupt path:
  - ebi_irq passes through a 2-flop synchroniser to give irq_level.
  - irq_rise = irq_level & ~irq_level_d.
  - Runs independently of the bus state machine.
- Reset asserted mid-transaction: strobes, cs and oe go inactive asynchronously; no rsp_valid; the transaction is lost.
- rsp_valid has no backpressure; the consumer must accept it.

Optional Feature:
- Macro: EBI_ARDY_EN.
- Defined:
  - After the minimum STROBE_CYC cycles, STROBE extends while ebi_ardy=0 (sampled through a 2-flop synchroniser).
  - Read data is captured in the cycle synchronised ardy is seen high.
  - If extension reaches ARDY_TIMEOUT cycles: strobe ends, HOLD runs, rsp_valid fires with rsp_err=1 and rsp_rdata=16'hDEAD.
- Not defined: ebi_ardy is ignored, strobe length is exactly STROBE_CYC, and rsp_err is constant 0.

Test Plan:
- Reset then write addr 19'h00032, data 16'hA5C3 (defaults) -> cs low cycles 1-8; wr low cycles 3-6 with ebi_data_o=A5C3 and oe=1; rsp_valid in cycle 9 with rsp_rdata=0; req_ready=1 in cycle 9.
- Read addr 19'h00010, target drives 16'h1234 during strobe -> rd low 4 cycles, rsp_rdata=1234, req_ready low until cycle 10 (TURN_CYC=1).
- Back-to-back writes with req_valid held -> exactly one cs-high cycle between them, second transaction's cycles identical to the first.
- SETUP_CYC=0, HOLD_CYC=0, STROBE_CYC=1 -> cs and wr low the same single cycle, rsp_valid the next cycle.
- Assert rst in cycle 4 of a write -> cs, wr high and oe=0 immediately, no rsp_valid; after release, req_ready=1 and a new read completes normally.
- EBI_ARDY_EN, ARDY_TIMEOUT=8: ardy held 0 -> rsp_err=1, rsp_rdata=DEAD; ardy rises 3 cycles late -> read completes 3+sync cycles later, rsp_err=0. Separately, pulse ebi_irq high for 3 cycles -> irq_rise one pulse 2 cycles later.
